// File: rtl/memshare_seq_ctrl_pkg.sv
// memshare sequencer shared configuration:
// FSM states, page field offsets and default parameter values.
package memShare_config_pkg;

    localparam int DEF_SHARE_GROUP_SIZE = 8;
    localparam int DEF_GROUP_NUM        = 2;
    localparam int DEF_SEQ_SIZE         = 4;
    localparam int DEF_REGFILE_RD_CYCLE = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_EMIT    = 2'd2
    } seq_state_t;

    // page layout is {shift, delta, last}
    localparam int PG_LAST_BIT  = 0;
    localparam int PG_DELTA_LSB = 1;

    function automatic int pg_shift_lsb(input int shift_w);
        return PG_DELTA_LSB + shift_w;
    endfunction

endpackage

// File: rtl/memshare_seq_regfile.sv
// Page register file: one write port, synchronous read
// with a configurable pipeline depth; contents are never reset.
module memshare_seq_regfile #(
    parameter  int DEPTH    = 256,
    parameter  int WIDTH    = 7,
    parameter  int RD_CYCLE = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             sys_clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem  [DEPTH];
    logic [WIDTH-1:0] pipe [RD_CYCLE];

    // Write and first read stage share an edge, so a colliding read sees old data.
    always_ff @(posedge sys_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        pipe[0] <= mem[raddr];
        for (int i = 1; i < RD_CYCLE; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign rdata = pipe[RD_CYCLE-1];

endmodule

// File: rtl/memshare_seq_ctrl.sv
// memshare sequence controller: round-robin request arbiter
// and IDLE/RD_WAIT/EMIT sequencer walking pages in the register file.
module memshare_seq_ctrl
    import memShare_config_pkg::*;
#(
    parameter  int SHARE_GROUP_SIZE = DEF_SHARE_GROUP_SIZE,
    parameter  int GROUP_NUM        = DEF_GROUP_NUM,
    parameter  int SEQ_SIZE         = DEF_SEQ_SIZE,
    parameter  int REGFILE_RD_CYCLE = DEF_REGFILE_RD_CYCLE,
    localparam int SHIFT_W  = $clog2(SHARE_GROUP_SIZE),
    localparam int PAGE_W   = 2*SHIFT_W + 1,
    localparam int PAGE_NUM = 2**SHARE_GROUP_SIZE,
    localparam int CH_W     = (GROUP_NUM > 1) ? $clog2(GROUP_NUM) : 1
) (
    input  logic                                  sys_clk,
    input  logic                                  rst,
    input  logic [GROUP_NUM*SHARE_GROUP_SIZE-1:0] rqst_flag_i,
    input  logic [GROUP_NUM-1:0]                  rqst_valid_i,
    output logic [GROUP_NUM-1:0]                  rqst_ready_o,
    output logic [SHIFT_W-1:0]                    shift_o,
    output logic [CH_W-1:0]                       shift_ch_o,
    output logic                                  shift_last_o,
    output logic                                  shift_valid_o,
    input  logic                                  shift_ready_i,
    output logic                                  seq_err_o,
    output logic                                  busy_o,
    input  logic [SHARE_GROUP_SIZE-1:0]           rf_waddr_i,
    input  logic [PAGE_W-1:0]                     rf_wdata_i,
    input  logic                                  rf_we_i
);

    localparam int IDX_W  = (SEQ_SIZE > 1) ? $clog2(SEQ_SIZE) : 1;
    localparam int SH_LSB = pg_shift_lsb(SHIFT_W);

    seq_state_t                  state_q, state_d;
    logic [CH_W-1:0]             ch_q, ch_d, lg_q, lg_d;
    logic [SHARE_GROUP_SIZE-1:0] addr_q, addr_d, raddr;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [1:0]                  cnt_q, cnt_d;
    logic [PAGE_W-1:0]           page_q, page_d, rf_rdata;
    logic                        gnt_any;
    logic [CH_W-1:0]             gnt_ch;
    logic [SHARE_GROUP_SIZE-1:0] gnt_flag;
    logic                        pg_last, last_now;
    logic [SHIFT_W-1:0]          pg_shift, pg_delta;

    memshare_seq_regfile #(
        .DEPTH    (PAGE_NUM),
        .WIDTH    (PAGE_W),
        .RD_CYCLE (REGFILE_RD_CYCLE)
    ) u_regfile (
        .sys_clk (sys_clk),
        .we      (rf_we_i),
        .waddr   (rf_waddr_i),
        .wdata   (rf_wdata_i),
        .raddr   (raddr),
        .rdata   (rf_rdata)
    );

    assign pg_last  = page_q[PG_LAST_BIT];
    assign pg_shift = page_q[SH_LSB +: SHIFT_W];
    assign pg_delta = page_q[PG_DELTA_LSB +: SHIFT_W];
    assign last_now = pg_last | (idx_q == IDX_W'(SEQ_SIZE-1));
    assign busy_o   = (state_q != ST_IDLE);
    assign gnt_flag = rqst_flag_i[gnt_ch*SHARE_GROUP_SIZE +: SHARE_GROUP_SIZE];

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        int c;
        c       = 0;
        gnt_any = 1'b0;
        gnt_ch  = '0;
        for (int i = 0; i < GROUP_NUM; i++) begin
            c = (int'(lg_q) + 1 + i) % GROUP_NUM;
            if (!gnt_any && rqst_valid_i[c]) begin
                gnt_any = 1'b1;
                gnt_ch  = CH_W'(c);
            end
        end
    end

    // Next-state, read address and output decode.
    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        lg_d          = lg_q;
        addr_d        = addr_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        page_d        = page_q;
        raddr         = addr_q;
        rqst_ready_o  = '0;
        shift_valid_o = 1'b0;
        shift_o       = '0;
        shift_ch_o    = '0;
        shift_last_o  = 1'b0;
        seq_err_o     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    rqst_ready_o[gnt_ch] = 1'b1;
                    ch_d  = gnt_ch;
                    lg_d  = gnt_ch;
                    addr_d = gnt_flag;
                    raddr  = gnt_flag;
                    if (gnt_flag != '0) begin
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == 2'(REGFILE_RD_CYCLE-1)) begin
                    page_d  = rf_rdata;
                    state_d = ST_EMIT;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_EMIT: begin
                shift_valid_o = 1'b1;
                shift_o       = pg_shift;
                shift_ch_o    = ch_q;
                shift_last_o  = last_now;
                if (shift_ready_i) begin
                    if (last_now) begin
                        seq_err_o = ~pg_last;
                        state_d   = ST_IDLE;
                    end else begin
                        addr_d  = addr_q + SHARE_GROUP_SIZE'(pg_delta);
                        raddr   = addr_d;
                        idx_d   = idx_q + 1'b1;
                        cnt_d   = '0;
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state register; channel 0 holds first priority out of reset.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            lg_q    <= CH_W'(GROUP_NUM-1);
            addr_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            page_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            lg_q    <= lg_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            page_q  <= page_d;
        end
    end

endmodule
